// File: rtl/pifo_pkg.sv
// ---------------------------------------------------------------------------
// pifo_pkg
// Definitions shared between the rank-computing front end (pifo_rank_enq)
// and the Astra_PIFO it feeds.
//   PTW        : rank (priority) width
//   MTW        : metadata width carried alongside each rank
//   EMPTY_RANK : all-ones rank; the PIFO reports this for an empty child,
//                so the front end must never push it as a real rank.
// ---------------------------------------------------------------------------
package pifo_pkg;

    localparam int PTW = 16;
    localparam int MTW = 32;

    localparam logic [PTW-1:0] EMPTY_RANK = '1;

endpackage : pifo_pkg

// File: rtl/pifo_sat_add.sv
// ---------------------------------------------------------------------------
// pifo_sat_add
// Unsigned adder that saturates at 2**W-2, so its result can never collide
// with the all-ones EMPTY_RANK value used by the PIFO.
// Ports:
//   a : W-bit base value (the rank just assigned)
//   b : BW-bit increment (the weighted packet length)
//   y : W-bit saturated sum
// ---------------------------------------------------------------------------
module pifo_sat_add #(
    parameter int W  = 16,
    parameter int BW = 16
) (
    input  logic [W-1:0]  a,
    input  logic [BW-1:0] b,
    output logic [W-1:0]  y
);

    // One guard bit above the wider operand catches every carry-out.
    localparam int SW = ((W > BW) ? W : BW) + 1;
    localparam logic [SW-1:0] SAT_MAX = SW'({W{1'b1}}) - SW'(1);

    logic [SW-1:0] sum;

    always_comb begin
        sum = SW'(a) + SW'(b);
        y   = (sum > SAT_MAX) ? SAT_MAX[W-1:0] : sum[W-1:0];
    end

endmodule : pifo_sat_add

// File: rtl/pifo_rank_enq.sv
// ---------------------------------------------------------------------------
// pifo_rank_enq
// Start-time fair queuing front end for an Astra_PIFO. Each accepted
// descriptor gets rank = max(vtime, finish[flow]); the flow's finish tag then
// advances by its length scaled down by a per-flow weight shift. Pops from
// the PIFO report the dequeued rank, which drags virtual time forward.
// Ports:
//   i_clk, i_arst_n          : clock, asynchronous active-low reset
//   i_valid / o_in_ready     : descriptor handshake
//   i_flow_id, i_len, i_meta : descriptor fields
//   i_wshift                 : 4-bit weight shift per flow (quasi-static)
//   i_pifo_ready             : PIFO can take a push
//   o_push, o_push_data      : one-cycle push of {meta, rank} to the PIFO
//   i_pop_valid, i_pop_rank  : rank of each entry the PIFO dequeues
//   o_occ                    : entries currently held by the PIFO
//   o_err                    : sticky flag, pop seen with nothing in flight
// ---------------------------------------------------------------------------
module pifo_rank_enq #(
    parameter int PTW  = pifo_pkg::PTW,
    parameter int MTW  = pifo_pkg::MTW,
    parameter int FIDW = 2,
    parameter int LW   = 16,
    parameter int CAP  = 64
) (
    input  logic                      i_clk,
    input  logic                      i_arst_n,
    input  logic                      i_valid,
    output logic                      o_in_ready,
    input  logic [FIDW-1:0]           i_flow_id,
    input  logic [LW-1:0]             i_len,
    input  logic [MTW-1:0]            i_meta,
    input  logic [4*(2**FIDW)-1:0]    i_wshift,
    input  logic                      i_pifo_ready,
    output logic                      o_push,
    output logic [MTW+PTW-1:0]        o_push_data,
    input  logic                      i_pop_valid,
    input  logic [PTW-1:0]            i_pop_rank,
    output logic [$clog2(CAP+1)-1:0]  o_occ,
    output logic                      o_err
);

    localparam int NFLOW = 2**FIDW;
    localparam int OCCW  = $clog2(CAP+1);

    logic [PTW-1:0]  finish_q [NFLOW];
    logic [PTW-1:0]  vtime_q;
    logic [OCCW-1:0] occ_q;

    logic            xfer;
    logic [PTW-1:0]  cur_finish;
    logic [PTW-1:0]  rank;
    logic [PTW-1:0]  next_finish;
    logic [3:0]      shamt;
    logic [LW-1:0]   inc;

    // Rank uses the registered vtime, so a pop landing in the same cycle
    // only affects later transfers. The finish tag is read combinationally,
    // which lets back-to-back transfers of one flow chain without a bubble.
    always_comb begin
        cur_finish = finish_q[i_flow_id];
        shamt      = i_wshift[4*i_flow_id +: 4];
        inc        = i_len >> shamt;
        rank       = (cur_finish > vtime_q) ? cur_finish : vtime_q;
    end

    // Gating with i_arst_n keeps the handshake closed while reset is held.
    assign o_in_ready = i_arst_n & i_pifo_ready & (occ_q < OCCW'(CAP));
    assign xfer       = i_valid & o_in_ready;
    assign o_occ      = occ_q;

    pifo_sat_add #(
        .W  (PTW),
        .BW (LW)
    ) u_sat_add (
        .a (rank),
        .b (inc),
        .y (next_finish)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            // NOTE: the flow table is a handful of flat flops, so it is
            // cleared in the reset branch like any other state; a RAM could
            // not be reset this way.
            for (int f = 0; f < NFLOW; f++) begin
                finish_q[f] <= '0;
            end
            vtime_q     <= '0;
            occ_q       <= '0;
            o_push      <= 1'b0;
            o_push_data <= '0;
            o_err       <= 1'b0;
        end else begin
            o_push <= xfer;

            if (xfer) begin
                finish_q[i_flow_id] <= next_finish;
                o_push_data         <= {i_meta, rank};
            end

            if (i_pop_valid && (i_pop_rank > vtime_q)) begin
                vtime_q <= i_pop_rank;
            end

            // A transfer can never coincide with occ == CAP, so only the
            // empty side needs guarding.
            case ({xfer, i_pop_valid})
                2'b10: occ_q <= occ_q + OCCW'(1);
                2'b01: begin
                    if (occ_q == '0) begin
                        o_err <= 1'b1;
                    end else begin
                        occ_q <= occ_q - OCCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : pifo_rank_enq

// File: tb/tb_pifo_rank_enq.sv
// ---------------------------------------------------------------------------
// tb_pifo_rank_enq
// Directed scenarios with literal rank expectations, then randomized traffic.
// A behavioural model (integer arithmetic on per-flow finish tags, vtime and
// an occupancy count) predicts every output and is compared each cycle.
// ---------------------------------------------------------------------------
module tb_pifo_rank_enq;
    import pifo_pkg::*;

    localparam int FIDW  = 2;
    localparam int NFLOW = 4;
    localparam int LW    = 16;
    localparam int CAP   = 64;
    localparam int OCCW  = $clog2(CAP+1);
    localparam int RMAX  = 65534;

    logic                   i_clk = 1'b0;
    logic                   i_arst_n = 1'b0;
    logic                   i_valid = 1'b0;
    logic                   o_in_ready;
    logic [FIDW-1:0]        i_flow_id = '0;
    logic [LW-1:0]          i_len = '0;
    logic [MTW-1:0]         i_meta = '0;
    logic [4*NFLOW-1:0]     i_wshift = '0;
    logic                   i_pifo_ready = 1'b1;
    logic                   o_push;
    logic [MTW+PTW-1:0]     o_push_data;
    logic                   i_pop_valid = 1'b0;
    logic [PTW-1:0]         i_pop_rank = '0;
    logic [OCCW-1:0]        o_occ;
    logic                   o_err;

    pifo_rank_enq #(
        .PTW (PTW), .MTW (MTW), .FIDW (FIDW), .LW (LW), .CAP (CAP)
    ) dut (
        .i_clk        (i_clk),
        .i_arst_n     (i_arst_n),
        .i_valid      (i_valid),
        .o_in_ready   (o_in_ready),
        .i_flow_id    (i_flow_id),
        .i_len        (i_len),
        .i_meta       (i_meta),
        .i_wshift     (i_wshift),
        .i_pifo_ready (i_pifo_ready),
        .o_push       (o_push),
        .o_push_data  (o_push_data),
        .i_pop_valid  (i_pop_valid),
        .i_pop_rank   (i_pop_rank),
        .o_occ        (o_occ),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int               m_finish [NFLOW];
    int               m_vtime;
    int               m_occ;
    bit               m_err;
    bit               m_push;
    logic [MTW+PTW-1:0] m_data;

    task automatic model_reset();
        for (int f = 0; f < NFLOW; f++) m_finish[f] = 0;
        m_vtime = 0;
        m_occ   = 0;
        m_err   = 1'b0;
        m_push  = 1'b0;
        m_data  = '0;
    endtask

    task automatic model_edge();
        int  f, r, nf, ws;
        bit  take;
        take   = i_valid && i_pifo_ready && (m_occ < CAP);
        m_push = take;
        if (take) begin
            f  = int'(i_flow_id);
            ws = int'((i_wshift >> (4*f)) & 16'hF);
            r  = (m_vtime > m_finish[f]) ? m_vtime : m_finish[f];
            nf = r + (int'(i_len) >> ws);
            if (nf > RMAX) nf = RMAX;
            m_finish[f] = nf;
            m_data      = {i_meta, PTW'(r)};
        end
        if (i_pop_valid && int'(i_pop_rank) > m_vtime) m_vtime = int'(i_pop_rank);
        if (take && !i_pop_valid) m_occ++;
        else if (!take && i_pop_valid) begin
            if (m_occ == 0) m_err = 1'b1;
            else            m_occ--;
        end
    endtask

    always @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) model_reset();
        else           model_edge();
    end

    // ---------------- per-cycle compare ----------------
    logic [PTW-1:0] rank_log [$];

    always @(negedge i_clk) begin
        if (i_arst_n) begin
            check("push", o_push, m_push);
            check("in_ready", o_in_ready, i_pifo_ready && (m_occ < CAP));
            check("occ", o_occ, m_occ);
            check("err", o_err, m_err);
            if (m_push) check("push_data", o_push_data, m_data);
            if (o_push) rank_log.push_back(o_push_data[PTW-1:0]);
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input int f, input int len);
        i_valid   = 1'b1;
        i_flow_id = FIDW'(f);
        i_len     = LW'(len);
        i_meta    = $urandom;
        cyc();
        i_valid   = 1'b0;
    endtask

    task automatic pop(input int r);
        i_pop_valid = 1'b1;
        i_pop_rank  = PTW'(r);
        cyc();
        i_pop_valid = 1'b0;
    endtask

    // Checks the rank 'back' entries before the latest logged push.
    task automatic expect_log(input string name, input int back, input int exp);
        @(negedge i_clk);
        #1;
        if (rank_log.size() > back) begin
            check(name, rank_log[rank_log.size()-1-back], exp);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no push logged, expected rank %0d", name, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;

        model_reset();
        #2;
        check("rst_push", o_push, 0);
        check("rst_data", o_push_data, 0);
        check("rst_occ", o_occ, 0);
        check("rst_err", o_err, 0);
        check("rst_ready", o_in_ready, 0);
        cyc();
        cyc();
        i_arst_n = 1'b1;
        cyc();

        // Back-to-back flow0 transfers: 100 then 50.
        i_valid = 1'b1; i_flow_id = 0; i_len = 100; i_meta = 32'hA0;
        cyc();
        i_len = 50; i_meta = 32'hA1;
        cyc();
        i_valid = 1'b0;
        expect_log("f0_first_rank", 1, 0);
        expect_log("f0_second_rank", 0, 100);

        send(1, 40);
        expect_log("f1_first_rank", 0, 0);
        pop(100);
        send(1, 10);
        expect_log("f1_after_vtime", 0, 100);

        i_wshift[8 +: 4] = 4'd2;
        send(2, 400);
        expect_log("f2_weighted", 0, 100);
        send(2, 4);
        expect_log("f2_finish200", 0, 200);

        send(0, 10);
        expect_log("f0_finish150", 0, 150);

        send(3, 65400);
        expect_log("f3_rank100", 0, 100);
        send(3, 100);
        expect_log("f3_rank65500", 0, 65500);
        send(3, 5);
        expect_log("f3_clamped", 0, 65534);
        check("f3_not_empty", rank_log[$] == EMPTY_RANK, 0);
        check("occ_after_directed", o_occ, 9);

        // Fill to capacity with no pops.
        i_valid = 1'b1; i_flow_id = 0; i_len = 1;
        guard = 0;
        while (o_in_ready && guard < 200) begin
            cyc();
            guard++;
        end
        check("full_occ", o_occ, CAP);
        check("full_ready", o_in_ready, 0);

        // Pop while full: the blocked descriptor does not transfer.
        i_pop_valid = 1'b1; i_pop_rank = 0;
        cyc();
        check("pop_from_full", o_occ, CAP-1);
        cyc();
        check("pop_and_push", o_occ, CAP-1);
        i_pop_valid = 1'b0;
        cyc();
        check("refill", o_occ, CAP);
        i_valid = 1'b0;

        pop(0);
        i_pifo_ready = 1'b0;
        i_valid = 1'b1;
        repeat (6) cyc();
        check("pifo_blocked_occ", o_occ, CAP-1);
        check("pifo_blocked_ready", o_in_ready, 0);
        i_valid = 1'b0;
        i_pifo_ready = 1'b1;

        // Drain, then underflow.
        repeat (CAP-1) pop($urandom_range(0, 20000));
        check("drained_occ", o_occ, 0);
        check("drained_err", o_err, 0);
        pop(5);
        check("underflow_err", o_err, 1);
        check("underflow_occ", o_occ, 0);

        // Mid-stream asynchronous reset.
        i_valid = 1'b1; i_flow_id = 1; i_len = 300;
        cyc();
        cyc();
        @(posedge i_clk);
        #3;
        i_arst_n = 1'b0;
        #1;
        check("mid_rst_push", o_push, 0);
        check("mid_rst_data", o_push_data, 0);
        check("mid_rst_occ", o_occ, 0);
        check("mid_rst_err", o_err, 0);
        check("mid_rst_ready", o_in_ready, 0);
        cyc();
        cyc();
        i_valid = 1'b0;
        i_arst_n = 1'b1;
        cyc();
        send(0, 10);
        expect_log("post_rst_rank", 0, 0);

        // Randomized traffic.
        for (int f = 0; f < NFLOW; f++) i_wshift[4*f +: 4] = 4'($urandom_range(0, 3));
        for (int c = 0; c < 3000; c++) begin
            int pr;
            i_valid      = ($urandom % 4) != 0;
            i_flow_id    = FIDW'($urandom);
            i_len        = LW'($urandom_range(0, 1500));
            i_meta       = $urandom;
            i_pifo_ready = ($urandom % 8) != 0;
            i_pop_valid  = ($urandom % 3) == 0;
            pr = m_vtime + $urandom_range(0, 300);
            if (pr > RMAX) pr = RMAX;
            i_pop_rank   = PTW'(pr);
            cyc();
        end
        i_valid = 1'b0;
        i_pop_valid = 1'b0;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pifo_rank_enq
